// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receptor: FSM state encoding,
// default parameter values and a small Gray helper function.
package gray_pkg;

  // Default Gray word width and error counter width
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_ERR_W = 8;

  // Receptor FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } rx_state_t;

  // Binary to Gray conversion of a 16-bit value (upper bits unused for narrower words)
  function automatic logic [15:0] bin2gray16(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray to binary converter: bin[MSB] = g[MSB],
// bin[i] = bin[i+1] ^ g[i], i.e. each binary bit is the XOR of all Gray
// bits at or above its position.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Prefix-XOR from the MSB downward
  always_comb begin
    o_bin = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_receptor.sv
// Gray-code receptor: converts sampled Gray words to binary, tracks the
// observed counter with an IDLE/SYNC/LOCKED/FAULT state machine and flags
// illegal steps (anything other than hold or +1 modulo 2^WIDTH while locked).
//
// Optional feature macro: GRAY_RX_ERRCNT_EN
//   defined   -> err_count is a saturating counter of step errors
//   undefined -> err_count is tied to zero, no counter register exists
module gray_receptor
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ERR_W = DEFAULT_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid_out,
  output logic             locked,
  output logic             step_error,
  output logic [ERR_W-1:0] err_count
);

  rx_state_t        r_state;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_bin_out;
  logic             r_valid_out;
  logic             r_locked;
  logic             r_step_error;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_inc;
  logic             w_same;
  logic             w_next;
  logic             w_bad_step;

  gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .i_gray (gray_in),
    .o_bin  (w_bin)
  );

  assign w_inc      = r_prev + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_same     = (w_bin == r_prev);
  assign w_next     = (w_bin == w_inc);
  // An illegal step can only be detected while locked
  assign w_bad_step = valid_in && (r_state == ST_LOCKED) && !w_same && !w_next;

  // FSM, previous-sample tracking and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_prev       <= {WIDTH{1'b0}};
      r_bin_out    <= {WIDTH{1'b0}};
      r_valid_out  <= 1'b0;
      r_locked     <= 1'b0;
      r_step_error <= 1'b0;
    end else begin
      r_valid_out  <= valid_in;
      r_step_error <= 1'b0;
      if (valid_in) begin
        r_bin_out <= w_bin;
      end else begin
        r_bin_out <= r_bin_out;
      end

      case (r_state)
        ST_IDLE: begin
          r_locked <= 1'b0;
          if (valid_in) begin
            r_prev  <= w_bin;
            r_state <= ST_SYNC;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // FAULT lasts one cycle; a sample arriving in it is judged as in SYNC
        ST_SYNC, ST_FAULT: begin
          if (valid_in && w_next) begin
            r_prev   <= w_bin;
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end else if (valid_in) begin
            r_prev   <= w_bin;
            r_state  <= ST_SYNC;
            r_locked <= 1'b0;
          end else begin
            r_state  <= ST_SYNC;
            r_locked <= 1'b0;
          end
        end

        ST_LOCKED: begin
          if (w_bad_step) begin
            r_prev       <= w_bin;
            r_state      <= ST_FAULT;
            r_locked     <= 1'b0;
            r_step_error <= 1'b1;
          end else if (valid_in && w_next) begin
            r_prev   <= w_bin;
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out    = r_bin_out;
  assign valid_out  = r_valid_out;
  assign locked     = r_locked;
  assign step_error = r_step_error;

`ifdef GRAY_RX_ERRCNT_EN
  logic [ERR_W-1:0] r_err_count;

  // Saturating count of illegal Gray steps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= {ERR_W{1'b0}};
    end else if (w_bad_step && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_gray_receptor.sv
// Directed self-checking bench for gray_receptor (WIDTH=4, ERR_W=2).
module tb_gray_receptor;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic [3:0] gray_in;
  logic [3:0] bin_out;
  logic       valid_out;
  logic       locked;
  logic       step_error;
  logic [1:0] err_count;

  int n_checks;
  int n_fail;
  int exp_err;
  int p;

  gray_receptor #(
    .WIDTH (4),
    .ERR_W (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .gray_in    (gray_in),
    .bin_out    (bin_out),
    .valid_out  (valid_out),
    .locked     (locked),
    .step_error (step_error),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one valid sample for one clock edge, then sample outputs
  task automatic drive(input logic [3:0] g);
    @(negedge clk);
    valid_in = 1'b1;
    gray_in  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err();
`ifdef GRAY_RX_ERRCNT_EN
    exp_err = (exp_err < 3) ? exp_err + 1 : 3;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_err  = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    gray_in  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bin", bin_out, 0);
    check("rst_vout", valid_out, 0);
    check("rst_locked", locked, 0);
    check("rst_serr", step_error, 0);
    check("rst_errcnt", err_count, 0);

    @(negedge clk);
    reset = 1'b0;

    // Acquire lock: 0000, 0001, 0011, hold, 0010
    drive(4'b0000);
    check("s0_vout", valid_out, 1);
    check("s0_bin", bin_out, 0);
    check("s0_locked", locked, 0);
    drive(4'b0001);
    check("s1_bin", bin_out, 1);
    check("s1_locked", locked, 1);
    drive(4'b0011);
    check("s2_bin", bin_out, 2);
    check("s2_locked", locked, 1);
    check("s2_serr", step_error, 0);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0011);
      check("hold_bin", bin_out, 2);
      check("hold_serr", step_error, 0);
      check("hold_locked", locked, 1);
    end
    drive(4'b0010);
    check("s3_bin", bin_out, 3);
    check("s3_locked", locked, 1);

    // Illegal step 3 -> 5, FAULT for one cycle, then relock at 6
    drive(4'b0111);
    bump_err();
    check("flt_serr", step_error, 1);
    check("flt_bin", bin_out, 5);
    check("flt_locked", locked, 0);
    check("flt_errcnt", err_count, exp_err);
    idle_cycle();
    check("flt_serr_pulse", step_error, 0);
    check("flt_vout_idle", valid_out, 0);
    check("flt_bin_hold", bin_out, 5);
    check("flt_sync_locked", locked, 0);
    drive(4'b0101);
    check("relock_bin", bin_out, 6);
    check("relock_locked", locked, 1);

    // Count up to 14, then sixteen more legal steps including the 15->0 wrap
    for (int n = 7; n <= 30; n++) begin
      drive(to_gray(n));
      check("step_bin", bin_out, n % 16);
      check("step_locked", locked, 1);
      check("step_serr", step_error, 0);
      check("step_errcnt", err_count, exp_err);
    end
    idle_cycle();
    check("idle_vout", valid_out, 0);
    check("idle_bin", bin_out, 14);

    // Five faults: jump +2 (error), then +1 during FAULT relocks
    p = 14;
    for (int k = 0; k < 5; k++) begin
      drive(to_gray(p + 2));
      bump_err();
      check("sat_serr", step_error, 1);
      check("sat_errcnt", err_count, exp_err);
      drive(to_gray(p + 3));
      check("sat_relock", locked, 1);
      check("sat_serr_low", step_error, 0);
      p = (p + 3) % 16;
    end
    check("sat_final", err_count, exp_err);

    // Asynchronous reset between edges while locked
    #2;
    reset = 1'b1;
    #1;
    check("arst_bin", bin_out, 0);
    check("arst_vout", valid_out, 0);
    check("arst_locked", locked, 0);
    check("arst_serr", step_error, 0);
    check("arst_errcnt", err_count, 0);
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    exp_err  = 0;
    drive(4'b0110);
    check("post_vout", valid_out, 1);
    check("post_bin", bin_out, 4);
    check("post_locked", locked, 0);
    check("post_serr", step_error, 0);
    drive(4'b0111);
    check("post_bin2", bin_out, 5);
    check("post_locked2", locked, 1);
    check("post_errcnt", err_count, 0);

    idle_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
